maxpool2d_psram_engine: RTL and testbench

Parametrised successor to the single-shot PSRAM max-pool block. Performs true 2-D KxK max pooling with configurable stride over an HWC tensor held in PSRAM. Fetches every window word by word over the PSRAM controller's start/done interface and writes each pooled word back. Adds lane-parallel compare, runtime signed/unsigned and ReLU modes, and a progress/busy interface; sits between the layer sequencer and EF_PSRAM_CTRL_V2.

---
 rtl/maxpool2d_psram_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_maxpool2d_psram_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2d_psram_engine.sv
// Strided KxK 2-D max pooling over an HWC tensor held in PSRAM.
// Every window tap is fetched one word at a time over the controller start/done handshake, and each pooled word is written back.
module maxpool2d_psram_engine #(
    parameter int unsigned IN_W       = 40,
    parameter int unsigned IN_H       = 4,
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned KERNEL     = 2,
    parameter int unsigned STRIDE     = 2,
    parameter int unsigned ACTIV_BITS = 16,
    parameter int unsigned ADDR_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] input_addr,
    input  logic [ADDR_WIDTH-1:0] output_addr,
    input  logic                  signed_mode,
    input  logic                  relu_en,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           out_count,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  mem_rd_wr,
    output logic                  mem_start,
    input  logic                  mem_done
);
    localparam int unsigned LANES = 32 / ACTIV_BITS;
    localparam int unsigned CW    = CHANNELS / LANES;
    localparam int unsigned OUT_W = (IN_W - KERNEL) / STRIDE + 1;
    localparam int unsigned OUT_H = (IN_H - KERNEL) / STRIDE + 1;
    localparam int unsigned CNT_W = 16;

    localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(KERNEL - 1);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(CW - 1);
    localparam logic [CNT_W-1:0] OX_LAST = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] OY_LAST = CNT_W'(OUT_H - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_WAIT = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]            state, state_d;
    logic [CNT_W-1:0]      oy, ox, c, ky, kx;
    logic [CNT_W-1:0]      oy_d, ox_d, c_d, ky_d, kx_d;
    logic [31:0]           acc, acc_d;
    logic [ADDR_WIDTH-1:0] in_base, in_base_d, out_base, out_base_d;
    logic                  sgn, sgn_d, relu, relu_d;
    logic                  busy_d, done_d, mem_start_d, mem_rd_wr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [31:0]           mem_wdata_d;
    logic [15:0]           out_count_d;

    function automatic logic [ADDR_WIDTH-1:0] tap_addr(input logic [ADDR_WIDTH-1:0] base,
                                                       input logic [CNT_W-1:0] oy_i, ox_i, c_i, ky_i, kx_i);
        logic [31:0] y, x, off;
        y   = 32'(oy_i) * 32'(STRIDE) + 32'(ky_i);
        x   = 32'(ox_i) * 32'(STRIDE) + 32'(kx_i);
        off = ((y * 32'(IN_W) + x) * 32'(CW) + 32'(c_i)) * 32'd4;
        return base + ADDR_WIDTH'(off);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] res_addr(input logic [ADDR_WIDTH-1:0] base,
                                                       input logic [CNT_W-1:0] oy_i, ox_i, c_i);
        logic [31:0] off;
        off = ((32'(oy_i) * 32'(OUT_W) + 32'(ox_i)) * 32'(CW) + 32'(c_i)) * 32'd4;
        return base + ADDR_WIDTH'(off);
    endfunction

    // Per-lane max; a tie keeps the accumulated value
    function automatic logic [31:0] lane_max(input logic [31:0] a, input logic [31:0] b, input logic sg);
        logic [31:0]           r;
        logic [ACTIV_BITS-1:0] la, lb;
        r = a;
        for (int l = 0; l < int'(LANES); l++) begin
            la = a[l*ACTIV_BITS +: ACTIV_BITS];
            lb = b[l*ACTIV_BITS +: ACTIV_BITS];
            if (sg ? ($signed(lb) > $signed(la)) : (lb > la)) begin
                r[l*ACTIV_BITS +: ACTIV_BITS] = lb;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] apply_relu(input logic [31:0] v, input logic en);
        logic [31:0] r;
        r = v;
        for (int l = 0; l < int'(LANES); l++) begin
            if (en && v[l*ACTIV_BITS + ACTIV_BITS - 1]) begin
                r[l*ACTIV_BITS +: ACTIV_BITS] = '0;
            end
        end
        return r;
    endfunction

    // Next-state, loop counters and next values of every registered output
    always_comb begin
        state_d     = state;
        oy_d        = oy;
        ox_d        = ox;
        c_d         = c;
        ky_d        = ky;
        kx_d        = kx;
        acc_d       = acc;
        in_base_d   = in_base;
        out_base_d  = out_base;
        sgn_d       = sgn;
        relu_d      = relu;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        out_count_d = out_count;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RD_REQ;
                    oy_d        = '0;
                    ox_d        = '0;
                    c_d         = '0;
                    ky_d        = '0;
                    kx_d        = '0;
                    acc_d       = '0;
                    in_base_d   = input_addr;
                    out_base_d  = output_addr;
                    sgn_d       = signed_mode;
                    relu_d      = relu_en;
                    out_count_d = '0;
                    mem_addr_d  = tap_addr(input_addr, '0, '0, '0, '0, '0);
                end
            end
            S_RD_REQ: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (mem_done) begin
                    acc_d = (ky == '0 && kx == '0) ? mem_rdata : lane_max(acc, mem_rdata, sgn);
                    if (kx != K_LAST) begin
                        kx_d = kx + CNT_W'(1);
                    end else begin
                        kx_d = '0;
                        ky_d = (ky != K_LAST) ? ky + CNT_W'(1) : '0;
                    end
                    if (kx == K_LAST && ky == K_LAST) begin
                        state_d     = S_WR_REQ;
                        mem_addr_d  = res_addr(out_base, oy, ox, c);
                        mem_wdata_d = apply_relu(acc_d, sgn && relu);
                    end else begin
                        state_d    = S_RD_REQ;
                        mem_addr_d = tap_addr(in_base, oy, ox, c, ky_d, kx_d);
                    end
                end
            end
            S_WR_REQ: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (mem_done) begin
                    out_count_d = out_count + 16'd1;
                    if (c != C_LAST) begin
                        c_d = c + CNT_W'(1);
                    end else begin
                        c_d = '0;
                        if (ox != OX_LAST) begin
                            ox_d = ox + CNT_W'(1);
                        end else begin
                            ox_d = '0;
                            oy_d = (oy != OY_LAST) ? oy + CNT_W'(1) : '0;
                        end
                    end
                    if (c == C_LAST && ox == OX_LAST && oy == OY_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_RD_REQ;
                        mem_addr_d = tap_addr(in_base, oy_d, ox_d, c_d, '0, '0);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        mem_start_d = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
        mem_rd_wr_d = !((state_d == S_WR_REQ) || (state_d == S_WR_WAIT));
        busy_d      = (state_d == S_RD_REQ) || (state_d == S_RD_WAIT) ||
                      (state_d == S_WR_REQ) || (state_d == S_WR_WAIT);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            oy        <= '0;
            ox        <= '0;
            c         <= '0;
            ky        <= '0;
            kx        <= '0;
            acc       <= '0;
            in_base   <= '0;
            out_base  <= '0;
            sgn       <= 1'b0;
            relu      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_count <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd_wr <= 1'b1;
            mem_start <= 1'b0;
        end else begin
            state     <= state_d;
            oy        <= oy_d;
            ox        <= ox_d;
            c         <= c_d;
            ky        <= ky_d;
            kx        <= kx_d;
            acc       <= acc_d;
            in_base   <= in_base_d;
            out_base  <= out_base_d;
            sgn       <= sgn_d;
            relu      <= relu_d;
            busy      <= busy_d;
            done      <= done_d;
            out_count <= out_count_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_rd_wr <= mem_rd_wr_d;
            mem_start <= mem_start_d;
        end
    end
endmodule

// File: tb/tb_maxpool2d_psram_engine.sv
// Bench for maxpool2d_psram_engine: two configurations against a shared PSRAM model with a
// window-by-window reference pooler computed straight from the tensor layout.
module tb_maxpool2d_psram_engine;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: 4x4x2, K=2, S=2, 16-bit lanes.  Instance B: 4x4x8, K=3, S=1, 8-bit lanes.
    logic        a_start, a_sg, a_rl, a_busy, a_done, a_rdwr, a_mstart, a_mdone;
    logic [23:0] a_in, a_out, a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic [15:0] a_cnt;
    logic        b_start, b_sg, b_rl, b_busy, b_done, b_rdwr, b_mstart, b_mdone;
    logic [23:0] b_in, b_out, b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic [15:0] b_cnt;

    maxpool2d_psram_engine #(.IN_W(4), .IN_H(4), .CHANNELS(2), .KERNEL(2), .STRIDE(2),
                             .ACTIV_BITS(16), .ADDR_WIDTH(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .input_addr(a_in), .output_addr(a_out),
        .signed_mode(a_sg), .relu_en(a_rl), .busy(a_busy), .done(a_done), .out_count(a_cnt),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_rd_wr(a_rdwr),
        .mem_start(a_mstart), .mem_done(a_mdone));

    maxpool2d_psram_engine #(.IN_W(4), .IN_H(4), .CHANNELS(8), .KERNEL(3), .STRIDE(1),
                             .ACTIV_BITS(8), .ADDR_WIDTH(24)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .input_addr(b_in), .output_addr(b_out),
        .signed_mode(b_sg), .relu_en(b_rl), .busy(b_busy), .done(b_done), .out_count(b_cnt),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_rd_wr(b_rdwr),
        .mem_start(b_mstart), .mem_done(b_mdone));

    int errors = 0;
    int checks = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    bit long_delay = 1'b0;
    int fixed_delay = 1;
    bit stab_en = 1'b1;

    logic [31:0] mem [bit [23:0]];
    logic [23:0] rd_log[$], wr_a[$], exp_rd[$], exp_wa[$];
    logic [31:0] wr_d[$], exp_wd[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [23:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic g_busy(input int w);    return (w == 0) ? a_busy   : b_busy;   endfunction
    function automatic logic g_done(input int w);    return (w == 0) ? a_done   : b_done;   endfunction
    function automatic logic g_mstart(input int w);  return (w == 0) ? a_mstart : b_mstart; endfunction
    function automatic logic g_rdwr(input int w);    return (w == 0) ? a_rdwr   : b_rdwr;   endfunction
    function automatic logic [23:0] g_addr(input int w);  return (w == 0) ? a_addr  : b_addr;  endfunction
    function automatic logic [31:0] g_wdata(input int w); return (w == 0) ? a_wdata : b_wdata; endfunction
    function automatic logic [15:0] g_cnt(input int w);   return (w == 0) ? a_cnt   : b_cnt;   endfunction

    always @(negedge clk) begin
        if (a_done) done_cnt_a++;
        if (b_done) done_cnt_b++;
    end

    // PSRAM controller model: answers each mem_start after a delay and checks the request stays put
    task automatic serve(input int w);
        logic [23:0] ad;
        logic        rw;
        logic [31:0] wd;
        int          n;
        forever begin
            @(negedge clk);
            if (w == 0) a_mdone = 1'b0; else b_mdone = 1'b0;
            if (g_mstart(w) && rst_n) begin
                ad = g_addr(w); rw = g_rdwr(w); wd = g_wdata(w);
                if (rw) rd_log.push_back(ad);
                else begin wr_a.push_back(ad); wr_d.push_back(wd); mem[ad] = wd; end
                n = long_delay ? int'($urandom_range(1, 20)) : fixed_delay;
                repeat (n) @(negedge clk);
                if (stab_en && rst_n) begin
                    check("hold_addr", g_addr(w), ad);
                    check("hold_rdwr", g_rdwr(w), rw);
                    if (!rw) check("hold_wdata", g_wdata(w), wd);
                    check("mstart_single", g_mstart(w), 1'b0);
                end
                if (w == 0) begin a_mdone = 1'b1; a_rdata = rw ? rd_mem(ad) : $urandom; end
                else        begin b_mdone = 1'b1; b_rdata = rw ? rd_mem(ad) : $urandom; end
            end
        end
    endtask

    initial serve(0);
    initial serve(1);

    task automatic fill_input(input int w, input logic [23:0] ib, input int mode);
        int cw;
        logic [23:0] a;
        cw = (w == 0) ? 1 : 2;
        mem.delete();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                for (int c = 0; c < cw; c++) begin
                    a = 24'(32'(ib) + 32'(((y * 4 + x) * cw + c) * 4));
                    case (mode)
                        0:       mem[a] = {16'(16 * y + x + 256), 16'(16 * y + x)};
                        1:       mem[a] = $urandom;
                        default: mem[a] = {16'($urandom_range(32'h8000, 32'hFFF0)),
                                           16'($urandom_range(32'h8000, 32'hFFF0))};
                    endcase
                end
    endtask

    // Reference pooler: every output word is the lane-wise max over its KxK window
    task automatic build_model(input int w, input logic [23:0] ib, input logic [23:0] ob,
                               input bit sg, input bit rl);
        int k, s, ab, lanes, cw, ow, oh, v, mask;
        int best[4];
        logic [23:0] a;
        logic [31:0] word, rw;
        k  = (w == 0) ? 2 : 3;  s = (w == 0) ? 2 : 1;  ab = (w == 0) ? 16 : 8;
        lanes = 32 / ab;  cw = ((w == 0) ? 2 : 8) / lanes;
        ow = (4 - k) / s + 1;  oh = (4 - k) / s + 1;  mask = (1 << ab) - 1;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int c = 0; c < cw; c++) begin
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++) begin
                            a = 24'(32'(ib) + 32'((((oy * s + ky) * 4 + ox * s + kx) * cw + c) * 4));
                            exp_rd.push_back(a);
                            rw = rd_mem(a);
                            for (int l = 0; l < lanes; l++) begin
                                v = int'((rw >> (l * ab)) & 32'(mask));
                                if (sg && v >= (1 << (ab - 1))) v -= (1 << ab);
                                if ((ky == 0 && kx == 0) || v > best[l]) best[l] = v;
                            end
                        end
                    word = 32'h0;
                    for (int l = 0; l < lanes; l++) begin
                        if (rl && sg && best[l] < 0) best[l] = 0;
                        word |= 32'(best[l] & mask) << (l * ab);
                    end
                    exp_wa.push_back(24'(32'(ob) + 32'(((oy * ow + ox) * cw + c) * 4)));
                    exp_wd.push_back(word);
                end
    endtask

    task automatic run_job(input int w, input logic [23:0] ib, input logic [23:0] ob,
                           input bit sg, input bit rl, input bit repulse, input string tag);
        int dc0;
        bit seen;
        build_model(w, ib, ob, sg, rl);
        rd_log.delete(); wr_a.delete(); wr_d.delete();
        dc0 = (w == 0) ? done_cnt_a : done_cnt_b;
        @(negedge clk);
        if (w == 0) begin a_in = ib; a_out = ob; a_sg = sg; a_rl = rl; a_start = 1'b1; end
        else        begin b_in = ib; b_out = ob; b_sg = sg; b_rl = rl; b_start = 1'b1; end
        @(negedge clk);
        a_start = 1'b0; b_start = 1'b0;
        check({tag, "_busy_rise"}, g_busy(w), 1'b1);
        check({tag, "_first_mstart"}, g_mstart(w), 1'b1);
        seen = 1'b0;
        for (int cyc = 0; cyc < 20000 && !seen; cyc++) begin
            @(negedge clk);
            if (repulse) begin
                if (w == 0) a_start = (cyc == 30); else b_start = (cyc == 30);
            end
            if (g_done(w)) seen = 1'b1;
        end
        a_start = 1'b0; b_start = 1'b0;
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_out_count"}, g_cnt(w), 16'(exp_wd.size()));
        @(negedge clk);
        check({tag, "_done_pulse_len"}, g_done(w), 1'b0);
        check({tag, "_busy_fall"}, g_busy(w), 1'b0);
        repeat (3) @(negedge clk);
        check({tag, "_done_count"}, ((w == 0) ? done_cnt_a : done_cnt_b) - dc0, 1);
        check({tag, "_n_reads"}, rd_log.size(), exp_rd.size());
        for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
            check({tag, "_rd_addr"}, rd_log[i], exp_rd[i]);
        check({tag, "_n_writes"}, wr_a.size(), exp_wa.size());
        for (int i = 0; i < wr_a.size() && i < exp_wa.size(); i++) begin
            check({tag, "_wr_addr"}, wr_a[i], exp_wa[i]);
            check({tag, "_wr_data"}, wr_d[i], exp_wd[i]);
        end
    endtask

    initial begin
        logic [31:0] spec_words[4];
        bit seen, stray;
        spec_words[0] = 32'h01110011; spec_words[1] = 32'h01130013;
        spec_words[2] = 32'h01310031; spec_words[3] = 32'h01330033;
        rst_n = 1'b0;
        a_start = 0; a_sg = 0; a_rl = 0; a_in = '0; a_out = '0; a_mdone = 0; a_rdata = '0;
        b_start = 0; b_sg = 0; b_rl = 0; b_in = '0; b_out = '0; b_mdone = 0; b_rdata = '0;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            check("rst_busy", g_busy(w), 1'b0);
            check("rst_done", g_done(w), 1'b0);
            check("rst_mstart", g_mstart(w), 1'b0);
            check("rst_rdwr", g_rdwr(w), 1'b1);
            check("rst_addr", g_addr(w), 24'h0);
            check("rst_wdata", g_wdata(w), 32'h0);
            check("rst_count", g_cnt(w), 16'h0);
        end
        rst_n = 1'b1;

        // Ramp pattern: known pooled words at consecutive output addresses
        fill_input(0, 24'h001000, 0);
        run_job(0, 24'h001000, 24'h002000, 1'b0, 1'b0, 1'b0, "pattern");
        check("pattern_nwr", wr_d.size(), 4);
        for (int i = 0; i < wr_d.size() && i < 4; i++) begin
            check("pattern_word", wr_d[i], spec_words[i]);
            check("pattern_waddr", wr_a[i], 24'(24'h002000 + 24'(4 * i)));
        end

        // 0xFFFF in lane 0 of the first tap: -1 when signed, maximum when unsigned
        mem[24'h001000] = 32'h0100FFFF;
        run_job(0, 24'h001000, 24'h002000, 1'b1, 1'b0, 1'b0, "ffff_signed");
        if (wr_d.size() > 0) check("ffff_signed_w0", wr_d[0], 32'h01110011);
        run_job(0, 24'h001000, 24'h002000, 1'b0, 1'b0, 1'b0, "ffff_unsigned");
        if (wr_d.size() > 0) check("ffff_unsigned_w0", wr_d[0], 32'h0111FFFF);

        // All-negative lanes: ReLU clamps, without ReLU the least negative survives
        fill_input(0, 24'h005000, 2);
        run_job(0, 24'h005000, 24'h006000, 1'b1, 1'b1, 1'b0, "neg_relu");
        for (int i = 0; i < wr_d.size(); i++) check("neg_relu_zero", wr_d[i], 32'h0);
        run_job(0, 24'h005000, 24'h006000, 1'b1, 1'b0, 1'b0, "neg_norelu");
        run_job(0, 24'h005000, 24'h006000, 1'b0, 1'b1, 1'b0, "relu_unsigned");

        // Overlapping 3x3 windows, 8-bit lanes, random data and modes
        for (int r = 0; r < 3; r++) begin
            fill_input(1, 24'h010000, 1);
            run_job(1, 24'h010000, 24'h020000, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0, "k3s1");
        end

        // Random controller latency, re-pulsed start, input base wrapping past the top of memory
        long_delay = 1'b1;
        fill_input(0, 24'hFFFFF0, 1);
        run_job(0, 24'hFFFFF0, 24'h007000, 1'b1, 1'b0, 1'b1, "slow_wrap");
        fill_input(1, 24'h030000, 1);
        run_job(1, 24'h030000, 24'h040000, 1'b1, 1'b1, 1'b1, "slow_b");
        long_delay = 1'b0;

        // Reset while the third window's first read is outstanding
        fixed_delay = 6;
        fill_input(0, 24'h003000, 1);
        rd_log.delete(); wr_a.delete(); wr_d.delete();
        @(negedge clk);
        a_in = 24'h003000; a_out = 24'h004000; a_sg = 1'b0; a_rl = 1'b0; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
            @(negedge clk);
            if (rd_log.size() >= 9) seen = 1'b1;
        end
        check("rst_mid_reached", seen, 1'b1);
        @(negedge clk);
        check("rst_mid_count_before", a_cnt, 16'd2);
        check("rst_mid_busy_before", a_busy, 1'b1);
        stab_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", a_busy, 1'b0);
        check("rst_mid_mstart", a_mstart, 1'b0);
        check("rst_mid_count", a_cnt, 16'd0);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (a_mstart || a_busy) stray = 1'b1;
        end
        check("rst_stray_ignored", stray, 1'b0);
        stab_en = 1'b1;
        fixed_delay = 1;
        run_job(0, 24'h003000, 24'h004000, 1'b0, 1'b0, 1'b0, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
